// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-to-host receiver.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

    localparam int unsigned PS2_FRAME_BITS = 11;

    // A frame is good when the data byte plus its parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser, glitch filter and fall detector for the ps2_clk/ps2_data pin pair.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_filt,
    output logic clk_fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    pins_c;
    logic [1:0]    meta;
    logic [1:0]    sync;
    logic [1:0]    filt;
    logic [CW-1:0] cnt [2];

    // Bit 0 carries the clock line, bit 1 the data line.
    assign pins_c    = {ps2_data, ps2_clk};
    assign data_filt = filt[1];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            meta     <= 2'b11;
            sync     <= 2'b11;
            filt     <= 2'b11;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
            clk_fall <= 1'b0;
        end else begin
            meta     <= pins_c;
            sync     <= meta;
            clk_fall <= 1'b0;
            // A new level is accepted on its FILTER_LEN-th consecutive sample.
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
            if (sync[0] != filt[0] && cnt[0] == CW'(FILTER_LEN - 1) && filt[0]) begin
                clk_fall <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_packet_rx.sv
// PS/2 receiver: frame FSM, inter-bit timeout and packet assembler with valid/ready output.
module ps2_packet_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned PKT_BYTES   = 3,
    parameter int unsigned TIMEOUT_CYC = 5000,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   ps2_clk,
    input  logic                   ps2_data,
    output logic                   byte_valid,
    output logic [7:0]             byte_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [8*PKT_BYTES-1:0] pkt_data,
    output logic                   err_parity,
    output logic                   err_frame,
    output logic                   err_timeout,
    output logic                   err_overflow
);

    localparam int unsigned PW  = 8 * PKT_BYTES;
    localparam int unsigned BCW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);

    logic          data_f;
    logic          fall;
    ps2_rx_state_t state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;
    logic [BCW-1:0] bytecnt;
    logic [PW-1:0] asm_buf;
    logic [TW-1:0] tmo;
    logic [PW-1:0] pkt_asm_c;
    logic          tmo_active_c;
    logic          align_drop_c;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_filt (data_f),
        .clk_fall  (fall)
    );

    // Packet buffer with the byte just deframed dropped into slot bytecnt.
    always_comb begin
        pkt_asm_c = asm_buf;
        pkt_asm_c[{bytecnt, 3'b000} +: 8] = shreg;
    end

    assign tmo_active_c = (state != IDLE) || (bytecnt != '0);
    assign align_drop_c = (ALIGN_CHECK != 0) && (bytecnt == '0) && !shreg[3];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            bitcnt       <= '0;
            shreg        <= '0;
            par          <= 1'b0;
            bytecnt      <= '0;
            asm_buf      <= '0;
            tmo          <= '0;
            byte_valid   <= 1'b0;
            byte_data    <= '0;
            pkt_valid    <= 1'b0;
            pkt_data     <= '0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            byte_valid   <= 1'b0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end

            if (fall) begin
                // The fall cycle itself counts as the first elapsed cycle.
                tmo <= TW'(1);
                case (state)
                    IDLE: begin
                        if (!data_f) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end else begin
                            err_frame <= 1'b1;
                            bytecnt   <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {data_f, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= data_f;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!odd_parity_ok(shreg, par)) begin
                            err_parity <= 1'b1;
                            bytecnt    <= '0;
                        end else if (!data_f) begin
                            err_frame <= 1'b1;
                            bytecnt   <= '0;
                        end else begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                            if (!align_drop_c) begin
                                if (bytecnt == BCW'(PKT_BYTES - 1)) begin
                                    bytecnt <= '0;
                                    if (!pkt_valid || pkt_ready) begin
                                        pkt_data  <= pkt_asm_c;
                                        pkt_valid <= 1'b1;
                                    end else begin
                                        err_overflow <= 1'b1;
                                    end
                                end else begin
                                    asm_buf <= pkt_asm_c;
                                    bytecnt <= bytecnt + BCW'(1);
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (tmo_active_c) begin
                if (tmo >= TW'(TIMEOUT_CYC - 1)) begin
                    err_timeout <= 1'b1;
                    state       <= IDLE;
                    bytecnt     <= '0;
                    tmo         <= '0;
                end else begin
                    tmo <= tmo + TW'(1);
                end
            end else begin
                tmo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_packet_rx.sv
// Scoreboard bench for ps2_packet_rx: FILTER_LEN=1 instance plus a FILTER_LEN=4 glitch instance.
module tb_ps2_packet_rx;
    import ps2_pkg::*;

    localparam int unsigned TMO = 40;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        c_a = 1'b1, d_a = 1'b1, c_b = 1'b1, d_b = 1'b1;
    logic        pkt_ready = 1'b1;

    logic        byte_valid, pkt_valid, err_parity, err_frame, err_timeout, err_overflow;
    logic [7:0]  byte_data;
    logic [23:0] pkt_data;
    logic        byte_valid_b, pkt_valid_b, err_parity_b, err_frame_b, err_timeout_b, err_overflow_b;
    logic [7:0]  byte_data_b;
    logic [23:0] pkt_data_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_fall_cyc = 0;

    logic [7:0]  exp_byte[$];
    logic [23:0] exp_pkt[$];
    logic [23:0] exp_pkt_b[$];
    int          exp_err[$];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    ps2_packet_rx #(.FILTER_LEN(1), .PKT_BYTES(3), .TIMEOUT_CYC(TMO), .ALIGN_CHECK(1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ps2_clk(c_a), .ps2_data(d_a),
        .byte_valid(byte_valid), .byte_data(byte_data), .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready), .pkt_data(pkt_data), .err_parity(err_parity),
        .err_frame(err_frame), .err_timeout(err_timeout), .err_overflow(err_overflow)
    );

    ps2_packet_rx #(.FILTER_LEN(4), .PKT_BYTES(3), .TIMEOUT_CYC(200), .ALIGN_CHECK(1)) dut4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ps2_clk(c_b), .ps2_data(d_b),
        .byte_valid(byte_valid_b), .byte_data(byte_data_b), .pkt_valid(pkt_valid_b),
        .pkt_ready(1'b1), .pkt_data(pkt_data_b), .err_parity(err_parity_b),
        .err_frame(err_frame_b), .err_timeout(err_timeout_b), .err_overflow(err_overflow_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event value %h, nothing expected (t=%0t)", name, act, $time);
    endtask

    // Error code: 1 parity, 2 frame, 4 timeout, 8 overflow.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            logic [3:0] code;
            code = {err_overflow, err_timeout, err_frame, err_parity};
            if (byte_valid) begin
                if (exp_byte.size() == 0) unexpected("byte_valid", 32'(byte_data));
                else check("byte_data", 32'(byte_data), 32'(exp_byte.pop_front()));
            end
            if (pkt_valid && pkt_ready) begin
                if (exp_pkt.size() == 0) unexpected("pkt_handshake", 32'(pkt_data));
                else check("pkt_data", 32'(pkt_data), 32'(exp_pkt.pop_front()));
            end
            if (code != 4'd0) begin
                if (exp_err.size() == 0) unexpected("err_strobe", 32'(code));
                else check("err_code", 32'(code), 32'(exp_err.pop_front()));
                // Pin fall -> fall pulse is 3 cycles, then TMO cycles; allow edge-phase slack.
                if (err_timeout)
                    check("timeout_latency_ok", 32'((cyc - last_fall_cyc >= 41) && (cyc - last_fall_cyc <= 45)), 32'd1);
            end
            if (pkt_valid_b) begin
                if (exp_pkt_b.size() == 0) unexpected("pkt_b_handshake", 32'(pkt_data_b));
                else check("pkt_data_b", 32'(pkt_data_b), 32'(exp_pkt_b.pop_front()));
            end
            if (err_parity_b || err_frame_b || err_timeout_b || err_overflow_b)
                unexpected("err_b", 32'({err_overflow_b, err_timeout_b, err_frame_b, err_parity_b}));
        end
    end

    // sel=0: dut pins, 25ns half-period; sel=1: dut4 pins, 100ns half-period with 20ns clk glitches.
    task automatic send_frame(input bit sel, input logic [7:0] b, input bit par, input bit stop,
                              input int nbits);
        logic [10:0] fr;
        fr = {stop, par, b, 1'b0};
        @(negedge sys_clk);
        for (int i = 0; i < nbits; i++) begin
            if (sel) begin
                d_b = fr[i];
                #50 c_b = 1'b0;
                #100 c_b = 1'b1;
                #12 c_b = 1'b0;
                #20 c_b = 1'b1;
                #18;
            end else begin
                d_a = fr[i];
                #12 c_a = 1'b0;
                last_fall_cyc = cyc;
                #25 c_a = 1'b1;
                #13;
            end
        end
        if (sel) begin d_b = 1'b1; #200; end
        else begin d_a = 1'b1; #50; end
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input bit par);
        if (!sel) exp_byte.push_back(b);
        send_frame(sel, b, par, 1'b1, PS2_FRAME_BITS);
    endtask

    task automatic send_mouse_pkt(input bit sel);
        if (sel) exp_pkt_b.push_back(24'hFB0508);
        else     exp_pkt.push_back(24'hFB0508);
        send_byte(sel, 8'h08, 1'b0);
        send_byte(sel, 8'h05, 1'b1);
        send_byte(sel, 8'hFB, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check("rst_pkt_data", 32'(pkt_data), 32'd0);
        check("rst_errs", 32'({err_overflow, err_timeout, err_frame, err_parity}), 32'd0);
        check("rst_pkt_valid_b", 32'(pkt_valid_b), 32'd0);
        sys_rst = 1'b0;
        #100;

        // 1: plain mouse packet, consumer always ready
        send_mouse_pkt(1'b0);
        #200;
        check("t1_pkt_valid_low", 32'(pkt_valid), 32'd0);

        // 2: held packet, second packet overflows
        @(posedge sys_clk); #1 pkt_ready = 1'b0;
        send_mouse_pkt(1'b0);
        send_byte(1'b0, 8'h09, 1'b1);
        send_byte(1'b0, 8'h01, 1'b0);
        exp_err.push_back(8);
        send_byte(1'b0, 8'h02, 1'b0);
        #200;
        check("t2_pkt_valid_held", 32'(pkt_valid), 32'd1);
        check("t2_pkt_data_held", 32'(pkt_data), 32'hFB0508);
        @(posedge sys_clk); #1 pkt_ready = 1'b1;
        #100;
        check("t2_pkt_valid_after", 32'(pkt_valid), 32'd0);

        // 3: unsynced leading byte is dropped from the packet
        send_byte(1'b0, 8'h05, 1'b1);
        send_mouse_pkt(1'b0);
        #200;

        // 4: parity error then a good packet; stop-bit error then a good packet
        exp_err.push_back(1);
        send_frame(1'b0, 8'h08, 1'b1, 1'b1, PS2_FRAME_BITS);
        send_mouse_pkt(1'b0);
        #200;
        exp_err.push_back(2);
        send_frame(1'b0, 8'h08, 1'b0, 1'b0, PS2_FRAME_BITS);
        send_mouse_pkt(1'b0);
        #200;

        // 5: two bytes then silence -> timeout; next packet starts at byte0
        exp_err.push_back(4);
        send_byte(1'b0, 8'h08, 1'b0);
        send_byte(1'b0, 8'h05, 1'b1);
        #600;
        check("t5_timeout_seen", 32'(exp_err.size()), 32'd0);
        send_mouse_pkt(1'b0);
        #200;

        // 6: reset after data bit 3 (5 falls), then a clean packet
        send_frame(1'b0, 8'h08, 1'b0, 1'b1, 5);
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("t6_byte_data", 32'(byte_data), 32'd0);
        check("t6_pkt_data", 32'(pkt_data), 32'd0);
        check("t6_pkt_valid", 32'(pkt_valid), 32'd0);
        check("t6_errs", 32'({err_overflow, err_timeout, err_frame, err_parity, byte_valid}), 32'd0);
        sys_rst = 1'b0;
        #300;
        send_mouse_pkt(1'b0);
        #200;

        // 6b: FILTER_LEN=4 instance with 20ns clock glitches
        send_mouse_pkt(1'b1);
        #500;
        check("t6b_byte_data_b", 32'(byte_data_b), 32'hFB);

        check("left_exp_byte", 32'(exp_byte.size()), 32'd0);
        check("left_exp_pkt", 32'(exp_pkt.size()), 32'd0);
        check("left_exp_pkt_b", 32'(exp_pkt_b.size()), 32'd0);
        check("left_exp_err", 32'(exp_err.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
